// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch counting rising edges of a slow tick in BCD, with start/stop/clear control.
// The tick is synchronised into the clock_in domain and edge-detected before counting.
module stopwatch_bcd_counter #(
    parameter bit STOP_AT_MAX = 1'b0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       tick_s1;
    logic       tick_s2;
    logic       tick_prev;
    logic       tick_edge;
    logic       at_max;
    logic       next_overflow;
    logic [3:0] next_sec_ones;
    logic [3:0] next_sec_tens;
    logic [3:0] next_min_ones;
    logic [3:0] next_min_tens;

    // One pulse per rising edge of the synchronised tick, however long it stays high.
    assign tick_edge = tick_s2 & ~tick_prev;

    assign at_max = (min_tens == 4'd5) && (min_ones == 4'd9) &&
                    (sec_tens == 4'd5) && (sec_ones == 4'd9);

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        next_state    = state;
        next_overflow = 1'b0;
        next_sec_ones = sec_ones;
        next_sec_tens = sec_tens;
        next_min_ones = min_ones;
        next_min_tens = min_tens;

        if (clear) begin
            next_state    = ST_IDLE;
            next_sec_ones = 4'd0;
            next_sec_tens = 4'd0;
            next_min_ones = 4'd0;
            next_min_tens = 4'd0;
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (tick_edge) begin
                        if (at_max) begin
                            next_overflow = 1'b1;
                            if (STOP_AT_MAX) begin
                                next_state = ST_PAUSED;
                            end else begin
                                next_sec_ones = 4'd0;
                                next_sec_tens = 4'd0;
                                next_min_ones = 4'd0;
                                next_min_tens = 4'd0;
                            end
                        end else if (sec_ones != 4'd9) begin
                            next_sec_ones = sec_ones + 4'd1;
                        end else begin
                            next_sec_ones = 4'd0;
                            if (sec_tens != 4'd5) begin
                                next_sec_tens = sec_tens + 4'd1;
                            end else begin
                                next_sec_tens = 4'd0;
                                if (min_ones != 4'd9) begin
                                    next_min_ones = min_ones + 4'd1;
                                end else begin
                                    // min_tens < 5 here, since 59:59 took the at_max branch.
                                    next_min_ones = 4'd0;
                                    next_min_tens = min_tens + 4'd1;
                                end
                            end
                        end
                    end
                    // The tick above is counted first, then the pause takes effect.
                    if (start_stop) begin
                        next_state = ST_PAUSED;
                    end
                end
                ST_IDLE, ST_PAUSED: begin
                    if (start_stop) begin
                        next_state = ST_RUNNING;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_prev <= 1'b0;
            state     <= ST_IDLE;
            running   <= 1'b0;
            overflow  <= 1'b0;
            sec_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            min_ones  <= 4'd0;
            min_tens  <= 4'd0;
        end else begin
            tick_s1   <= tick_in;
            tick_s2   <= tick_s1;
            tick_prev <= tick_s2;
            state     <= next_state;
            running   <= (next_state == ST_RUNNING);
            overflow  <= next_overflow;
            sec_ones  <= next_sec_ones;
            sec_tens  <= next_sec_tens;
            min_ones  <= next_min_ones;
            min_tens  <= next_min_tens;
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter; drives one instance of each STOP_AT_MAX setting in lockstep.
module tb_stopwatch_bcd_counter;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic       w_running, w_overflow;
    logic [3:0] h_so, h_st, h_mo, h_mt;
    logic       h_running, h_overflow;
    logic [15:0] w_cnt, h_cnt;

    int total = 0;
    int bad = 0;
    int secs = 0;

    assign w_cnt = {w_mt, w_mo, w_st, w_so};
    assign h_cnt = {h_mt, h_mo, h_st, h_so};

    always #5 clock_in = ~clock_in;

    stopwatch_bcd_counter #(.STOP_AT_MAX(1'b0)) dut_wrap (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear),
        .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
        .running(w_running), .overflow(w_overflow)
    );

    stopwatch_bcd_counter #(.STOP_AT_MAX(1'b1)) dut_hold (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear),
        .sec_ones(h_so), .sec_tens(h_st), .min_ones(h_mo), .min_tens(h_mt),
        .running(h_running), .overflow(h_overflow)
    );

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    // Raise tick_in for `high` cycles (>=3); digits must hold for two edges and change on the third.
    task automatic tick_step(input int high, input bit counts);
        tick_in = 1'b1;
        step(2);
        check("tick_pre_wrap", w_cnt, to_bcd(secs));
        check("tick_pre_hold", h_cnt, to_bcd(secs));
        step(1);
        if (counts) secs = secs + 1;
        check("tick_post_wrap", w_cnt, to_bcd(secs));
        check("tick_post_hold", h_cnt, to_bcd(secs));
        if (high > 3) step(high - 3);
        tick_in = 1'b0;
        step(2);
    endtask

    task automatic ticks(input int n, input int high, input bit counts);
        for (int i = 0; i < n; i++) tick_step(high, counts);
    endtask

    task automatic check_both(input string tag, input logic [15:0] cnt, input logic run);
        check({tag, "_cnt_wrap"}, w_cnt, cnt);
        check({tag, "_cnt_hold"}, h_cnt, cnt);
        check({tag, "_run_wrap"}, 16'(w_running), 16'(run));
        check({tag, "_run_hold"}, 16'(h_running), 16'(run));
    endtask

    initial begin
        // Reset state
        step(1);
        check_both("reset", 16'h0000, 1'b0);
        check("reset_ovf_wrap", 16'(w_overflow), 16'h0);
        check("reset_ovf_hold", 16'(h_overflow), 16'h0);
        reset = 1'b0;
        step(1);

        // Run to 12:34, then assert reset between clock edges
        pulse_ss();
        check_both("start", 16'h0000, 1'b1);
        ticks(754, 3, 1'b1);
        check_both("at_1234", 16'h1234, 1'b1);
        #2 reset = 1'b1;
        #1 check_both("async_reset", 16'h0000, 1'b0);
        @(negedge clock_in);
        reset = 1'b0;
        secs = 0;
        step(1);
        ticks(3, 3, 1'b0);
        check_both("idle_ignores_ticks", 16'h0000, 1'b0);

        // 65 ticks, each high for 4 cycles
        pulse_ss();
        ticks(65, 4, 1'b1);
        check_both("at_0105", 16'h0105, 1'b1);

        // Long-held tick counts once
        pulse_clear();
        check_both("clear", 16'h0000, 1'b0);
        secs = 0;
        pulse_ss();
        ticks(58, 3, 1'b1);
        check_both("at_0058", 16'h0058, 1'b1);
        tick_step(100, 1'b1);
        check_both("held_high", 16'h0059, 1'b1);
        tick_step(3, 1'b1);
        check_both("after_held", 16'h0100, 1'b1);

        // Overflow at 59:59
        pulse_clear();
        secs = 0;
        pulse_ss();
        ticks(3599, 3, 1'b1);
        check_both("at_5959", 16'h5959, 1'b1);
        tick_in = 1'b1;
        step(2);
        check("ovf_pre_wrap", 16'(w_overflow), 16'h0);
        check("ovf_pre_hold", 16'(h_overflow), 16'h0);
        step(1);
        check("ovf_cnt_wrap", w_cnt, 16'h0000);
        check("ovf_pulse_wrap", 16'(w_overflow), 16'h1);
        check("ovf_run_wrap", 16'(w_running), 16'h1);
        check("ovf_cnt_hold", h_cnt, 16'h5959);
        check("ovf_pulse_hold", 16'(h_overflow), 16'h1);
        check("ovf_run_hold", 16'(h_running), 16'h0);
        step(1);
        check("ovf_end_wrap", 16'(w_overflow), 16'h0);
        check("ovf_end_hold", 16'(h_overflow), 16'h0);
        tick_in = 1'b0;
        step(2);
        // Resume: holding instance overflows again; wrapping instance is now paused at 00:00
        pulse_ss();
        check("resume_run_hold", 16'(h_running), 16'h1);
        check("resume_run_wrap", 16'(w_running), 16'h0);
        tick_in = 1'b1;
        step(3);
        check("ovf2_cnt_hold", h_cnt, 16'h5959);
        check("ovf2_pulse_hold", 16'(h_overflow), 16'h1);
        check("ovf2_run_hold", 16'(h_running), 16'h0);
        check("paused_cnt_wrap", w_cnt, 16'h0000);
        check("paused_ovf_wrap", 16'(w_overflow), 16'h0);
        tick_in = 1'b0;
        step(2);

        // Tick and start_stop in the same cycle
        pulse_clear();
        secs = 0;
        pulse_ss();
        ticks(10, 3, 1'b1);
        check_both("at_0010", 16'h0010, 1'b1);
        tick_in = 1'b1;
        step(2);
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        check_both("tick_ss_running", 16'h0011, 1'b0);
        tick_in = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(2);
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        check_both("tick_ss_paused", 16'h0011, 1'b1);
        tick_in = 1'b0;
        step(2);

        // clear, tick and start_stop together
        pulse_clear();
        secs = 0;
        pulse_ss();
        ticks(207, 3, 1'b1);
        check_both("at_0327", 16'h0327, 1'b1);
        tick_in = 1'b1;
        step(2);
        start_stop = 1'b1;
        clear = 1'b1;
        step(1);
        start_stop = 1'b0;
        clear = 1'b0;
        check_both("clear_wins", 16'h0000, 1'b0);
        check("clear_ovf_wrap", 16'(w_overflow), 16'h0);
        check("clear_ovf_hold", 16'(h_overflow), 16'h0);
        tick_in = 1'b0;
        step(4);
        check_both("idle_after_clear", 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
